// File: rtl/rx_instruction_pkg.sv
// rx_instruction_pkg: shared definitions for the instruction receiver.
//   - state_t      : receiver states (IDLE / RECEIVING / FULL)
//   - baud defines : clk12 cycles per UART bit, as used by uart_tx/uart_rx
`ifndef B115200
`define B115200 104
`endif
`ifndef B57600
`define B57600 208
`endif
`ifndef B9600
`define B9600 1250
`endif

package rx_instruction_pkg;

  // IDLE: no bytes held; RECEIVING: partial word; FULL: word presented (valid=1)
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RECEIVING = 2'b01,
    FULL      = 2'b11
  } state_t;

  // Baud divisors at 12 MHz, available to code that prefers a typed constant
  localparam int BAUD_115200_DIV = 104;
  localparam int BAUD_57600_DIV  = 208;
  localparam int BAUD_9600_DIV   = 1250;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Ports:
//   clk   in  1  system clock
//   rstn  in  1  asynchronous reset, active-low
//   rx    in  1  serial input, idle high
//   rcv   out 1  one-cycle strobe: a byte with a valid stop bit was received
//   data  out 8  received byte, valid while rcv=1 (held afterwards)
module uart_rx #(
  parameter int BAUDRATE = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUDRATE / 2 - 1);

  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            rcv_reg, rcv_next;
  logic            rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      rcv_reg     <= 1'b0;
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      rcv_reg     <= rcv_next;
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    rcv_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (!rx_sync_reg) begin
          cnt_next   = '0;
          state_next = RX_START;
        end
      end
      RX_START: begin
        // Re-check the start bit at its midpoint to reject glitches
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = RX_STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RX_STOP: begin
        // A low stop bit is a framing error: the byte is silently dropped
        if (cnt_reg == BAUD_LAST) begin
          state_next = RX_IDLE;
          if (rx_sync_reg) begin
            rcv_next  = 1'b1;
            data_next = shift_reg;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rcv  = rcv_reg;
  assign data = data_reg;

endmodule

// File: rtl/rx_instruction.sv
// rx_instruction: assembles NBYTES UART bytes (little-endian) into one word
// and hands it to the consumer with a valid/ack handshake.
// Ports:
//   clk12    in  1  system clock (12 MHz)
//   rst      in  1  asynchronous reset, active-high
//   rx       in  1  UART serial input, idle high
//   instr    out W  assembled word, stable while valid=1
//   valid    out 1  word available, held until ack
//   ack      in  1  consumer took instr (only meaningful while valid=1)
//   busy     out 1  partial word in progress
//   overrun  out 1  sticky: byte dropped while FULL, cleared by ack
//   led      out 1  toggles on every completed word
`ifndef B115200
`define B115200 104
`endif

module rx_instruction
  import rx_instruction_pkg::*;
#(
  parameter int NBYTES   = 4,
  parameter int BAUDRATE = `B115200,
  parameter int TIMEOUT  = 12000
) (
  input  logic                clk12,
  input  logic                rst,
  input  logic                rx,
  output logic [8*NBYTES-1:0] instr,
  output logic                valid,
  input  logic                ack,
  output logic                busy,
  output logic                overrun,
  output logic                led
);

  localparam int W  = 8 * NBYTES;
  localparam int BW = $clog2(NBYTES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BI_LAST    = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic       rcv;
  logic [7:0] rcv_data;
  logic       rstn_int;

  assign rstn_int = ~rst;

  uart_rx #(
    .BAUDRATE(BAUDRATE)
  ) RX0 (
    .clk  (clk12),
    .rstn (rstn_int),
    .rx   (rx),
    .rcv  (rcv),
    .data (rcv_data)
  );

  state_t          state_reg, state_next;
  logic [BW-1:0]   byte_index_reg, byte_index_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            overrun_reg, overrun_next;
  logic            led_reg, led_next;
  logic [W-1:0]    instr_reg;
  logic            byte_we;
  logic [BW-1:0]   lane_sel;
  logic [NBYTES-1:0] lane_we;
  logic            start_word;

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_index_reg <= '0;
      timer_reg      <= '0;
      overrun_reg    <= 1'b0;
      led_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_index_reg <= byte_index_next;
      timer_reg      <= timer_next;
      overrun_reg    <= overrun_next;
      led_reg        <= led_next;
    end
  end

  // A byte opens a new word from IDLE, or from FULL when the ack in the
  // same cycle frees the buffer.
  assign start_word = rcv && ((state_reg == IDLE) || ((state_reg == FULL) && ack));

  always_comb begin
    state_next      = state_reg;
    byte_index_next = byte_index_reg;
    timer_next      = timer_reg;
    overrun_next    = overrun_reg;
    led_next        = led_reg;
    byte_we         = 1'b0;
    lane_sel        = '0;

    if ((state_reg == FULL) && ack) overrun_next = 1'b0;

    if (start_word) begin
      byte_we         = 1'b1;
      byte_index_next = BW'(1);
      timer_next      = '0;
      if (NBYTES == 1) begin
        state_next = FULL;
        led_next   = ~led_reg;
      end else begin
        state_next = RECEIVING;
      end
    end else begin
      case (state_reg)
        IDLE: ;
        RECEIVING: begin
          if (rcv) begin
            byte_we         = 1'b1;
            lane_sel        = byte_index_reg;
            byte_index_next = byte_index_reg + BW'(1);
            timer_next      = '0;
            if (byte_index_reg == BI_LAST) begin
              state_next = FULL;
              led_next   = ~led_reg;
            end
          end else if (timer_reg == TIMER_LAST) begin
            // Stale bytes stay in instr; they are overwritten by the next word
            state_next      = IDLE;
            byte_index_next = '0;
            timer_next      = '0;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        FULL: begin
          if (ack) begin
            state_next      = IDLE;
            byte_index_next = '0;
          end else if (rcv) begin
            overrun_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // One write enable per byte lane of the word
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign lane_we[gi] = byte_we && (lane_sel == BW'(gi));
    end
  endgenerate

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      instr_reg <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (lane_we[i]) instr_reg[8*i +: 8] <= rcv_data;
      end
    end
  end

  assign instr   = instr_reg;
  assign valid   = (state_reg == FULL);
  assign busy    = (state_reg == RECEIVING);
  assign overrun = overrun_reg;
  assign led     = led_reg;

endmodule

// File: tb/tb_rx_instruction.sv
module tb_rx_instruction;
  import rx_instruction_pkg::*;

  localparam int BAUD = BAUD_115200_DIV;

  logic        clk12 = 1'b0;
  logic        rst;
  logic        rx, rx1;
  logic        ack, ack1;
  logic [31:0] instr;
  logic [7:0]  instr1;
  logic        valid, busy, overrun, led;
  logic        valid1, busy1, overrun1, led1;

  int checks = 0;
  int errors = 0;
  bit got;

  always #42 clk12 = ~clk12;

  rx_instruction #(.NBYTES(4), .BAUDRATE(BAUD), .TIMEOUT(12000)) dut (
    .clk12(clk12), .rst(rst), .rx(rx), .instr(instr), .valid(valid),
    .ack(ack), .busy(busy), .overrun(overrun), .led(led)
  );

  rx_instruction #(.NBYTES(1), .BAUDRATE(BAUD), .TIMEOUT(12000)) dut1 (
    .clk12(clk12), .rst(rst), .rx(rx1), .instr(instr1), .valid(valid1),
    .ack(ack1), .busy(busy1), .overrun(overrun1), .led(led1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx1 = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    @(negedge clk12);
    drive(which, 1'b0);
    repeat (BAUD) @(negedge clk12);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      repeat (BAUD) @(negedge clk12);
    end
    drive(which, 1'b1);
    repeat (BAUD) @(negedge clk12);
  endtask

  // Returns #1 after the clock edge at which the receiver strobe rises
  task automatic wait_rcv(input int which, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (n < 12 * BAUD) begin
      if (((which == 0) ? dut.rcv : dut1.rcv) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk12);
      #1;
      n++;
    end
  endtask

  task automatic pulse_ack(input int which);
    @(negedge clk12);
    if (which == 0) ack = 1'b1; else ack1 = 1'b1;
    @(negedge clk12);
    if (which == 0) ack = 1'b0; else ack1 = 1'b0;
  endtask

  initial begin
    #(95000 * 84);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rx1 = 1'b1; ack = 1'b0; ack1 = 1'b0;
    repeat (3) @(negedge clk12);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_led", led, 1'b0);
    chk("rst_valid1", valid1, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk12);

    // ack while idle is ignored
    pulse_ack(0);
    @(negedge clk12);
    chk("idle_ack_valid", valid, 1'b0);
    chk("idle_ack_busy", busy, 1'b0);
    $display("step: idle ack ignored");

    // Single word 0x00100513
    send_byte(0, 8'h13);
    send_byte(0, 8'h05);
    chk("w1_busy", busy, 1'b1);
    pulse_ack(0);
    chk("w1_recv_ack_busy", busy, 1'b1);
    send_byte(0, 8'h10);
    chk("w1_valid_early", valid, 1'b0);
    fork
      send_byte(0, 8'h00);
      begin
        wait_rcv(0, got);
        chk("w1_rcv_seen", got, 1'b1);
        chk("w1_valid_at_rcv", valid, 1'b0);
        @(posedge clk12);
        #1;
        chk("w1_valid_latency", valid, 1'b1);
        chk("w1_instr", instr, 32'h00100513);
        chk("w1_led", led, 1'b1);
        chk("w1_busy_full", busy, 1'b0);
      end
    join
    pulse_ack(0);
    chk("w1_ack_valid", valid, 1'b0);
    chk("w1_ack_busy", busy, 1'b0);
    $display("step: single word instr=%h", instr);

    // Slow consumer: extra byte is dropped and flagged
    send_byte(0, 8'h13);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    chk("w2_valid", valid, 1'b1);
    chk("w2_instr", instr, 32'h00000013);
    chk("w2_led", led, 1'b0);
    send_byte(0, 8'hAA);
    chk("ovr_instr", instr, 32'h00000013);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_valid", valid, 1'b1);
    pulse_ack(0);
    chk("ovr_clear", overrun, 1'b0);
    chk("ovr_ack_valid", valid, 1'b0);
    $display("step: overrun handled");

    // Ack coincident with the first byte of the next word
    send_byte(0, 8'h04);
    send_byte(0, 8'h03);
    send_byte(0, 8'h02);
    send_byte(0, 8'h01);
    chk("w3_instr", instr, 32'h01020304);
    chk("w3_led", led, 1'b1);
    fork
      send_byte(0, 8'hEF);
      begin
        wait_rcv(0, got);
        chk("co_rcv_seen", got, 1'b1);
        ack = 1'b1;
        @(posedge clk12);
        #1;
        ack = 1'b0;
        chk("co_valid", valid, 1'b0);
        chk("co_busy", busy, 1'b1);
        chk("co_overrun", overrun, 1'b0);
      end
    join
    send_byte(0, 8'hBE);
    send_byte(0, 8'hAD);
    send_byte(0, 8'hDE);
    chk("co_word_valid", valid, 1'b1);
    chk("co_word_instr", instr, 32'hDEADBEEF);
    chk("co_word_led", led, 1'b0);
    pulse_ack(0);
    $display("step: coincident ack instr=deadbeef");

    // Inter-byte timeout discards a partial word
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    chk("to_busy", busy, 1'b1);
    repeat (11700) @(negedge clk12);
    chk("to_busy_before", busy, 1'b1);
    repeat (400) @(negedge clk12);
    chk("to_busy_after", busy, 1'b0);
    chk("to_valid_after", valid, 1'b0);
    send_byte(0, 8'h33);
    send_byte(0, 8'h44);
    chk("to_no_spurious", valid, 1'b0);
    chk("to_busy_new", busy, 1'b1);
    send_byte(0, 8'h55);
    send_byte(0, 8'h66);
    chk("to_valid", valid, 1'b1);
    chk("to_instr", instr, 32'h66554433);
    chk("to_led", led, 1'b1);
    pulse_ack(0);
    $display("step: timeout resync instr=66554433");

    // Asynchronous reset in the middle of a word
    send_byte(0, 8'hA1);
    send_byte(0, 8'hB2);
    chk("rm_busy", busy, 1'b1);
    @(posedge clk12);
    #17;
    rst = 1'b1;
    #1;
    chk("rm_instr", instr, 32'h0);
    chk("rm_valid", valid, 1'b0);
    chk("rm_busy0", busy, 1'b0);
    chk("rm_overrun", overrun, 1'b0);
    chk("rm_led", led, 1'b0);
    repeat (2) @(negedge clk12);
    rst = 1'b0;
    repeat (3) @(negedge clk12);
    send_byte(0, 8'hC0);
    send_byte(0, 8'hFF);
    send_byte(0, 8'hEE);
    send_byte(0, 8'h11);
    chk("rm_word_valid", valid, 1'b1);
    chk("rm_word_instr", instr, 32'h11EEFFC0);
    chk("rm_word_led", led, 1'b1);
    pulse_ack(0);
    $display("step: reset mid-word instr=11eeffc0");

    // NBYTES=1: single-byte words, ack coincident with the next byte
    fork
      send_byte(1, 8'h01);
      begin
        wait_rcv(1, got);
        chk("n1_rcv_seen", got, 1'b1);
        @(posedge clk12);
        #1;
        chk("n1_valid_a", valid1, 1'b1);
        chk("n1_instr_a", instr1, 8'h01);
        chk("n1_led_a", led1, 1'b1);
      end
    join
    fork
      send_byte(1, 8'h02);
      begin
        wait_rcv(1, got);
        chk("n1_rcv2_seen", got, 1'b1);
        chk("n1_valid_held", valid1, 1'b1);
        ack1 = 1'b1;
        @(posedge clk12);
        #1;
        ack1 = 1'b0;
        chk("n1_valid_b", valid1, 1'b1);
        chk("n1_instr_b", instr1, 8'h02);
        chk("n1_led_b", led1, 1'b0);
        chk("n1_overrun", overrun1, 1'b0);
      end
    join
    pulse_ack(1);
    chk("n1_ack_valid", valid1, 1'b0);
    chk("n1_busy", busy1, 1'b0);
    $display("step: single-byte words");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_instruction.md
Name: rx_instruction

Overview:
Receive-side counterpart of the register-file UART transmitter. Collects NBYTES consecutive bytes from the host over the UART rx line and assembles them little-endian into one instruction word, then presents the word with a valid/ack handshake to the core-side injector. An inter-byte timeout discards partial words so host and FPGA resynchronise after a glitch or a host restart.

Parameters:
NBYTES, 4, bytes per word (1..16); word width W = 8*NBYTES
BAUDRATE, `B115200, baud divisor passed to the uart_rx instance
TIMEOUT, 12000, clk12 cycles of rx silence that abort a partial word (1 ms at 12 MHz); must be > 1100

Ports:
clk12  in  1  system clock, 12 MHz
rst  in  1  asynchronous reset, active-high
rx  in  1  UART serial input, idle high
instr  out  W  assembled word; stable while valid=1
valid  out  1  word available; held until ack
ack  in  1  consumer has taken instr; sampled only while valid=1
busy  out  1  partial word in progress (state RECEIVING)
overrun  out  1  sticky: a byte arrived while FULL and was dropped; cleared by ack
led  out  1  toggles on every completed word (debug)

Behaviour:
- One clock, clk12. Reset is asynchronous and active-high: rst=1 immediately forces state IDLE, byte_index=0, timer=0, instr=0, valid=0, busy=0, overrun=0, led=0. Reset mid-word discards the partial word.
- uart_rx is driven with rstn = ~rst. Its rcv output is a one-cycle strobe with data[7:0] valid in the same cycle.
- States: IDLE (0 bytes held), RECEIVING (1..NBYTES-1 bytes held), FULL (valid=1).
- IDLE, rcv: byte goes to instr[7:0], byte_index=1, timer=0. Next state is RECEIVING, or FULL if NBYTES=1.
- RECEIVING, rcv: byte goes to instr[8*byte_index +: 8] and byte_index increments. When the last byte arrives (byte_index==NBYTES-1), the next state is FULL, valid=1 and led toggles.
- valid rises in the cycle after the rcv strobe of the final byte (1-cycle latency).
- RECEIVING, no rcv: timer increments. When timer==TIMEOUT-1, state goes to IDLE, byte_index=0, and instr bytes keep their stale values. timer resets to 0 on every rcv.
- FULL: instr is frozen. A rcv without ack drops the byte and sets overrun=1.
- FULL, ack without rcv: valid=0, overrun=0, next state IDLE.
- FULL, ack and rcv in the same cycle: the ack is honoured and the byte is kept as byte 0 of the next word. Next state is RECEIVING with byte_index=1, or FULL again if NBYTES=1 (valid stays 1, led toggles).
- ack while valid=0 is ignored.
- busy = (state == RECEIVING).
- Width rules: byte_index is $clog2(NBYTES+1) bits; timer is $clog2(TIMEOUT) bits and saturates by construction.

Decomposition:
- Shared package/header: the state encodings (IDLE=2'b00, RECEIVING=2'b01, FULL=2'b11) and the baud defines already used by uart_tx/uart_rx.
- Sub-module: the existing uart_rx (instance RX0). All assembly, timeout and handshake logic stays in rx_instruction, about 150 lines.

Test Plan:
- Single word: send bytes 0x13,0x05,0x10,0x00 at 115200 -> valid=1 one cycle after the 4th rcv, instr=32'h00100513, led=1. Pulse ack -> valid=0, state IDLE.
- Back-to-back with slow consumer: send word 0x00000013, withhold ack, send one more byte 0xAA -> instr unchanged, overrun=1. ack -> overrun=0, valid=0.
- Ack coincident with rcv: hold ack high across the first rcv of a second word 0xDEADBEEF (bytes EF,BE,AD,DE) -> first word released, second word assembles correctly, valid=1 with instr=32'hDEADBEEF.
- Timeout: send 0x11,0x22, go idle for >TIMEOUT cycles, then send 0x33,0x44,0x55,0x66 -> busy drops after timeout, final instr=32'h66554433 and no spurious valid earlier.
- Reset mid-word: assert rst asynchronously (not clock-aligned) after 2 bytes -> all outputs 0 immediately. Release, send 4 fresh bytes -> correct word.
- NBYTES=1 variant: stream 0x01,0x02 with ack held high -> valid stays high and instr follows 0x01 then 0x02, led toggles twice.
